// File: rtl/risc16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// risc16_mem_arbiter
//   Shares one single-port data RAM between the Risc_16_bit datapath load/store
//   port (C) and a program/debug loader (L). Round-robin between the two, one
//   transaction in flight, fixed memory read latency of MEM_LAT cycles.
//
//   Sequence per transaction: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
//   A request sampled in IDLE at cycle T strobes mem_en in T+1 and acks in
//   T+2+MEM_LAT. Every transaction occupies MEM_LAT+3 cycles.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata  CPU request; held stable until the c_ack cycle
//   c_ack, c_rdata             CPU completion pulse and read data
//   l_req/l_we/l_addr/l_wdata  loader request, same rules as the CPU port
//   l_ack, l_rdata             loader completion pulse and read data
//   mem_en/mem_we/mem_addr/mem_wdata  RAM strobe and command
//   mem_rdata                  RAM read data, valid MEM_LAT cycles after mem_en
//   busy                       high whenever a transaction is in progress
//   grant_id                   0 = CPU, 1 = loader owns current/last transaction
// ---------------------------------------------------------------------------
module risc16_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [1:0] r_state;
    logic       r_rr_last;   // port granted most recently; the other wins a tie
    logic [3:0] r_cnt;       // WAIT cycles remaining, 1 = last WAIT cycle

    logic       w_any;
    logic       w_pick;      // 0 = CPU, 1 = loader

    // CPU wins when it is alone or when the loader was served last.
    assign w_any  = c_req | l_req;
    assign w_pick = !(c_req && (!l_req || r_rr_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_cnt     <= 4'd0;
            c_ack     <= 1'b0;
            c_rdata   <= '0;
            l_ack     <= 1'b0;
            l_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            // Strobe and acks are single-cycle pulses.
            mem_en <= 1'b0;
            c_ack  <= 1'b0;
            l_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        grant_id  <= w_pick;
                        r_rr_last <= w_pick;
                        mem_we    <= w_pick ? l_we    : c_we;
                        mem_addr  <= w_pick ? l_addr  : c_addr;
                        mem_wdata <= w_pick ? l_wdata : c_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= LAT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        // Read data is captured for writes too; requester ignores it.
                        if (grant_id) begin
                            l_rdata <= mem_rdata;
                            l_ack   <= 1'b1;
                        end else begin
                            c_rdata <= mem_rdata;
                            c_ack   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_risc16_mem_arbiter
//   Directed bench. u_dut1 (MEM_LAT=1) carries most scenarios with an ack
//   scoreboard; u_dut3 (MEM_LAT=3) checks the longer-latency timing inline.
// ---------------------------------------------------------------------------
module tb_risc16_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT1 (MEM_LAT=1)
    logic        c_req, c_we, l_req, l_we;
    logic [15:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_ack, l_ack, mem_en, mem_we, busy, grant_id;
    logic [15:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;

    risc16_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    // DUT3 (MEM_LAT=3), CPU port only
    logic        d3_c_req, d3_c_we, d3_l_req, d3_l_we;
    logic [15:0] d3_c_addr, d3_c_wdata, d3_l_addr, d3_l_wdata;
    logic        d3_c_ack, d3_l_ack, d3_mem_en, d3_mem_we, d3_busy, d3_grant_id;
    logic [15:0] d3_c_rdata, d3_l_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

    risc16_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .c_req(d3_c_req), .c_we(d3_c_we), .c_addr(d3_c_addr), .c_wdata(d3_c_wdata),
        .c_ack(d3_c_ack), .c_rdata(d3_c_rdata),
        .l_req(d3_l_req), .l_we(d3_l_we), .l_addr(d3_l_addr), .l_wdata(d3_l_wdata),
        .l_ack(d3_l_ack), .l_rdata(d3_l_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
        .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata),
        .busy(d3_busy), .grant_id(d3_grant_id)
    );

    // RAM models
    logic [15:0] ram1 [0:1023];
    logic [15:0] ram3 [0:1023];
    logic [15:0] rd1;
    logic [15:0] p3 [0:2];
    int          wcnt = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            rd1 <= ram1[mem_addr[9:0]];
            if (mem_we) begin
                ram1[mem_addr[9:0]] <= mem_wdata;
                wcnt <= wcnt + 1;
            end
        end
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (d3_mem_en) p3[0] <= ram3[d3_mem_addr[9:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_mem_rdata = p3[2];

    // Checking
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic        port;   // 0 = CPU, 1 = loader
        logic        chkd;   // compare read data
        logic [15:0] data;
        int          at;     // expected ack cycle
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_en = 1'b0;

    task automatic push(input logic port, input logic chkd, input logic [15:0] data, input int at);
        exp_t e;
        e.port = port; e.chkd = chkd; e.data = data; e.at = at;
        sb.push_back(e);
    endtask

    // Monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en <= 1'b0;
        end else begin
            if (mem_en) chk("mem_en_b2b", {31'b0, prev_en}, 32'd0);
            prev_en <= mem_en;
            if (c_ack || l_ack) begin
                chk("ack_excl", {31'b0, c_ack & l_ack}, 32'd0);
                if (sb.size() == 0) begin
                    chk("ack_unexpected", {30'b0, l_ack, c_ack}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_port", {30'b0, l_ack, c_ack}, mon_e.port ? 32'd2 : 32'd1);
                    chk("ack_grant_id", {31'b0, grant_id}, {31'b0, mon_e.port});
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.at));
                    if (mon_e.chkd)
                        chk("ack_rdata", {16'b0, mon_e.port ? l_rdata : c_rdata}, {16'b0, mon_e.data});
                end
            end
        end
    end

    // Granted requester must hold req until its ack.
    a_c_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (c_req && busy && !grant_id && !c_ack) |=> c_req)
        else $error("protocol: c_req dropped before c_ack");
    a_l_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (l_req && busy && grant_id && !l_ack) |=> l_req)
        else $error("protocol: l_req dropped before l_ack");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0;
    int w0;

    initial begin
        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        d3_c_req = 0; d3_c_we = 0; d3_c_addr = 0; d3_c_wdata = 0;
        d3_l_req = 0; d3_l_we = 0; d3_l_addr = 0; d3_l_wdata = 0;
        for (int i = 0; i < 1024; i++) begin
            ram1[i] = 16'h0;
            ram3[i] = 16'h0;
        end
        ram1[16'h0010] = 16'hBEEF;
        ram3[16'h0020] = 16'hCAFE;

        repeat (2) step();
        chk("rst_busy",     {31'b0, busy},     32'd0);
        chk("rst_mem_en",   {31'b0, mem_en},   32'd0);
        chk("rst_grant_id", {31'b0, grant_id}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_acks",     {30'b0, l_ack, c_ack}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: CPU read, MEM_LAT=1
        t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        push(1'b0, 1'b1, 16'hBEEF, t0 + 3);
        step();
        chk("t1_mem_en",   {31'b0, mem_en},   32'd1);
        chk("t1_mem_we",   {31'b0, mem_we},   32'd0);
        chk("t1_mem_addr", {16'b0, mem_addr}, 32'h0010);
        chk("t1_busy",     {31'b0, busy},     32'd1);
        repeat (3) step();
        c_req = 0;

        // 2: loader write, then CPU read-back
        w0 = wcnt;
        t0 = cyc;
        l_req = 1; l_we = 1; l_addr = 16'h0100; l_wdata = 16'h1234;
        push(1'b1, 1'b0, 16'h0000, t0 + 3);
        repeat (4) step();
        l_req = 0; l_we = 0;
        t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 16'h0100;
        push(1'b0, 1'b1, 16'h1234, t0 + 3);
        repeat (4) step();
        c_req = 0;
        chk("t2_wstrobes", 32'(wcnt - w0), 32'd1);

        // 3: both requesting continuously after reset -> C,L,C,L
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        l_req = 1; l_we = 0; l_addr = 16'h0100;
        push(1'b0, 1'b1, 16'hBEEF, t0 + 3);
        push(1'b1, 1'b1, 16'h1234, t0 + 7);
        push(1'b0, 1'b1, 16'hBEEF, t0 + 11);
        push(1'b1, 1'b1, 16'h1234, t0 + 15);
        repeat (16) step();
        c_req = 0; l_req = 0;
        step();

        // 5: reset during WAIT of a loader read
        t0 = cyc;
        l_req = 1; l_we = 0; l_addr = 16'h0010;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("t5_busy",     {31'b0, busy},     32'd0);
        chk("t5_grant_id", {31'b0, grant_id}, 32'd0);
        chk("t5_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("t5_l_rdata",  {16'b0, l_rdata},  32'd0);
        chk("t5_c_rdata",  {16'b0, c_rdata},  32'd0);
        step();
        l_req = 0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("t5_idle_after", {31'b0, busy}, 32'd0);
        t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        push(1'b0, 1'b1, 16'hBEEF, t0 + 3);
        repeat (4) step();
        c_req = 0;

        // 6: loader request arrives during CPU ISSUE
        t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        push(1'b0, 1'b1, 16'hBEEF, t0 + 3);
        step();
        l_req = 1; l_we = 0; l_addr = 16'h0100;
        push(1'b1, 1'b1, 16'h1234, t0 + 7);
        repeat (3) step();
        chk("t6_addr_held", {16'b0, mem_addr}, 32'h0010);
        c_req = 0;
        step();
        chk("t6_l_mem_en",   {31'b0, mem_en},   32'd1);
        chk("t6_l_mem_addr", {16'b0, mem_addr}, 32'h0100);
        chk("t6_l_grant",    {31'b0, grant_id}, 32'd1);
        repeat (3) step();
        l_req = 0;

        // 4: MEM_LAT=3 CPU read on u_dut3
        t0 = cyc;
        d3_c_req = 1; d3_c_we = 0; d3_c_addr = 16'h0020;
        step();
        chk("t4_mem_en",   {31'b0, d3_mem_en},   32'd1);
        chk("t4_mem_addr", {16'b0, d3_mem_addr}, 32'h0020);
        chk("t4_busy_1",   {31'b0, d3_busy},     32'd1);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("t4_busy",   {31'b0, d3_busy},   32'd1);
            chk("t4_mem_en_low", {31'b0, d3_mem_en}, 32'd0);
            chk("t4_c_ack",  {31'b0, d3_c_ack},  (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) chk("t4_c_rdata", {16'b0, d3_c_rdata}, 32'hCAFE);
        end
        step();
        d3_c_req = 0;
        chk("t4_busy_end", {31'b0, d3_busy}, 32'd0);
        chk("t4_l_ack",    {31'b0, d3_l_ack}, 32'd0);

        repeat (4) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
